dcache_controller: RTL and testbench

- Direct-mapped, write-back, write-allocate L1 data cache.
- Sits between the CPU MEM stage and the off-chip data memory model.
- Returns hit data combinationally and raises a stall on a miss.
- Stall is held until the line is written back if dirty, refilled, and the access completes.

---
 rtl/cache_pkg.sv | 43 ++++
 rtl/dcache_sram.sv | 40 ++++
 rtl/dcache_controller.sv | 127 ++++++++++++
 tb/tb_dcache_controller.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared geometry, FSM encoding and line-entry layout for the L1 data cache.
package cache_pkg;
  localparam int unsigned ADDR_W        = 32;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned TAG_W         = 22;
  localparam int unsigned IDX_W         = 5;
  localparam int unsigned LINE_W        = 256;
  localparam int unsigned OFFSET_W      = 5;
  localparam int unsigned WORD_PER_LINE = 8;
  localparam int unsigned WSEL_W        = $clog2(WORD_PER_LINE);
  localparam int unsigned WORD_LSB      = OFFSET_W - WSEL_W;
  localparam int unsigned LINES         = 1 << IDX_W;
  localparam int unsigned LADDR_W       = TAG_W + IDX_W;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MISS       = 3'd1,
    ST_WRITEBACK  = 3'd2,
    ST_READMISS   = 3'd3,
    ST_READMISSOK = 3'd4
  } state_t;

  typedef struct packed {
    logic              valid;
    logic              dirty;
    logic [TAG_W-1:0]  tag;
    logic [LINE_W-1:0] data;
  } line_t;

  function automatic logic [WORD_W-1:0] sel_word(input logic [LINE_W-1:0] line,
                                                 input logic [WSEL_W-1:0] word);
    return line[word*WORD_W +: WORD_W];
  endfunction

  function automatic logic [LINE_W-1:0] merge_word(input logic [LINE_W-1:0] line,
                                                   input logic [WSEL_W-1:0] word,
                                                   input logic [WORD_W-1:0] data);
    logic [LINE_W-1:0] res;
    res = line;
    res[word*WORD_W +: WORD_W] = data;
    return res;
  endfunction
endpackage

// File: rtl/dcache_sram.sv
// Line storage: async read on two ports (CPU index, miss index), one synchronous write port.
module dcache_sram
  import cache_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx_a,
  output line_t            rd_line_a,
  input  logic [IDX_W-1:0] rd_idx_b,
  output line_t            rd_line_b,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  line_t            wr_line
);
  logic [LINES-1:0]  valid;
  logic [LINES-1:0]  dirty;
  logic [TAG_W-1:0]  tag  [LINES];
  logic [LINE_W-1:0] data [LINES];

  // Only the status bits need reset; tag/data are qualified by valid.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (we) begin
      valid[wr_idx] <= wr_line.valid;
      dirty[wr_idx] <= wr_line.dirty;
    end
  end

  always_ff @(posedge clk_i) begin
    if (we) begin
      tag[wr_idx]  <= wr_line.tag;
      data[wr_idx] <= wr_line.data;
    end
  end

  assign rd_line_a = {valid[rd_idx_a], dirty[rd_idx_a], tag[rd_idx_a], data[rd_idx_a]};
  assign rd_line_b = {valid[rd_idx_b], dirty[rd_idx_b], tag[rd_idx_b], data[rd_idx_b]};
endmodule

// File: rtl/dcache_controller.sv
// Direct-mapped write-back/write-allocate L1 D-cache: combinational hit path,
// miss FSM with registered memory controls.
module dcache_controller
  import cache_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);
  state_t             state, state_nxt;
  logic [LADDR_W-1:0] miss_laddr;
  logic [TAG_W-1:0]   cpu_tag, miss_tag;
  logic [IDX_W-1:0]   cpu_idx, miss_idx, wr_idx;
  logic [WSEL_W-1:0]  cpu_word;
  line_t              cpu_line, victim, wr_line;
  logic               req, hit, miss, write_hit, refill, sram_we;
  logic               en_nxt, wr_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [LINE_W-1:0]  data_nxt;
  logic               unused_bits;

  assign cpu_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign cpu_idx     = p1_addr_i[OFFSET_W +: IDX_W];
  assign cpu_word    = p1_addr_i[WORD_LSB +: WSEL_W];
  assign miss_tag    = miss_laddr[LADDR_W-1 -: TAG_W];
  assign miss_idx    = miss_laddr[IDX_W-1:0];
  assign unused_bits = ^{p1_addr_i[WORD_LSB-1:0], cpu_line.dirty};

  dcache_sram u_sram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_idx_a  (cpu_idx),
    .rd_line_a (cpu_line),
    .rd_idx_b  (miss_idx),
    .rd_line_b (victim),
    .we        (sram_we),
    .wr_idx    (wr_idx),
    .wr_line   (wr_line)
  );

  assign req        = p1_MemRead_i | p1_MemWrite_i;
  assign hit        = cpu_line.valid & (cpu_line.tag == cpu_tag);
  assign miss       = req & ~hit;
  assign p1_stall_o = miss;
  assign p1_data_o  = (p1_MemRead_i & ~p1_MemWrite_i & hit) ? sel_word(cpu_line.data, cpu_word)
                                                             : '0;

  // Stores only merge while no refill can claim the write port.
  assign write_hit = p1_MemWrite_i & hit & ((state == ST_IDLE) | (state == ST_READMISSOK));
  assign refill    = (state == ST_READMISS) & mem_ack_i;
  assign sram_we   = refill | write_hit;

  always_comb begin
    wr_idx  = cpu_idx;
    wr_line = '{valid: 1'b1, dirty: 1'b1, tag: cpu_tag,
                data: merge_word(cpu_line.data, cpu_word, p1_data_i)};
    if (refill) begin
      wr_idx  = miss_idx;
      wr_line = '{valid: 1'b1, dirty: 1'b0, tag: miss_tag, data: mem_data_i};
    end
  end

  // Miss address is captured so a CPU flush mid-miss cannot redirect the fill.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= ST_IDLE;
      miss_laddr   <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      state        <= state_nxt;
      mem_enable_o <= en_nxt;
      mem_write_o  <= wr_nxt;
      mem_addr_o   <= addr_nxt;
      mem_data_o   <= data_nxt;
      if ((state == ST_IDLE) && miss) miss_laddr <= p1_addr_i[ADDR_W-1:OFFSET_W];
    end
  end

  always_comb begin
    state_nxt = state;
    en_nxt    = mem_enable_o;
    wr_nxt    = mem_write_o;
    addr_nxt  = mem_addr_o;
    data_nxt  = mem_data_o;
    case (state)
      ST_IDLE: if (miss) state_nxt = ST_MISS;
      ST_MISS: begin
        en_nxt = 1'b1;
        if (victim.valid && victim.dirty) begin
          wr_nxt    = 1'b1;
          addr_nxt  = {victim.tag, miss_idx, {OFFSET_W{1'b0}}};
          data_nxt  = victim.data;
          state_nxt = ST_WRITEBACK;
        end else begin
          wr_nxt    = 1'b0;
          addr_nxt  = {miss_laddr, {OFFSET_W{1'b0}}};
          state_nxt = ST_READMISS;
        end
      end
      ST_WRITEBACK: if (mem_ack_i) begin
        wr_nxt    = 1'b0;
        addr_nxt  = {miss_laddr, {OFFSET_W{1'b0}}};
        state_nxt = ST_READMISS;
      end
      ST_READMISS: if (mem_ack_i) begin
        en_nxt    = 1'b0;
        state_nxt = ST_READMISSOK;
      end
      ST_READMISSOK: state_nxt = ST_IDLE;
      default:       state_nxt = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios plus random traffic checked
// against an array-based cache model and a latency-programmable memory model.
`timescale 1ns/1ps
module tb_dcache_controller;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  addr, wdata;
  logic         rd, wr;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [255:0] mem_rdata;
  logic         ack_rsp, ack_spur, mem_ack;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o, mem_write_o;

  assign mem_ack = ack_rsp | ack_spur;
  always #5 clk = ~clk;

  dcache_controller dut (
    .clk_i(clk), .rst_i(rst_n),
    .p1_addr_i(addr), .p1_data_i(wdata),
    .p1_MemRead_i(rd), .p1_MemWrite_i(wr),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o)
  );

  int errors = 0;
  int checks = 0;
  int lat = 10;

  typedef struct {
    logic [31:0]  addr;
    logic         wr;
    logic [255:0] data;
  } txn_t;
  txn_t txq[$];
  txn_t last_tx[$];

  logic [255:0] mem [logic [26:0]];

  // Cache model: what each line must hold after every completed access.
  logic         mv [32];
  logic         md [32];
  logic [21:0]  mt [32];
  logic [255:0] mdat [32];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void chk_line(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  function automatic logic [255:0] mem_get(input logic [26:0] la);
    logic [255:0] r;
    if (mem.exists(la)) return mem[la];
    for (int w = 0; w < 8; w++) r[w*32 +: 32] = 32'h9E37_79B9 * (32'(la) + 32'd1) + 32'(w);
    return r;
  endfunction

  function automatic txn_t get_tx(input int i);
    txn_t t;
    t = '{32'hFFFF_FFFF, 1'bx, '0};
    if (i < last_tx.size()) t = last_tx[i];
    return t;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 32; i++) begin
      mv[i] = 1'b0; md[i] = 1'b0; mt[i] = '0; mdat[i] = '0;
    end
  endfunction

  // Memory model: acks the lat-th cycle of every request, records each request once.
  initial begin
    int cnt;
    cnt = 0; ack_rsp = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      ack_rsp = 1'b0;
      if (!mem_enable_o) cnt = 0;
      else begin
        if (cnt == 0) txq.push_back('{mem_addr_o, mem_write_o, mem_data_o});
        cnt++;
        if (cnt >= lat) begin
          ack_rsp = 1'b1;
          cnt = 0;
          if (mem_write_o) mem[mem_addr_o[31:5]] = mem_data_o;
          else mem_rdata = mem_get(mem_addr_o[31:5]);
        end
      end
    end
  end

  // One CPU access, entered and left at #1 after a rising edge.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int stalls);
    logic [4:0]   ix;
    logic [21:0]  tg, oldtag;
    logic [2:0]   wd;
    logic         req, hitm, vdirty, isr;
    logic [255:0] old;
    logic [31:0]  exp_data;
    int           exp_s;
    ix = a[9:5]; tg = a[31:10]; wd = a[4:2];
    req = r | w; isr = r & ~w;
    hitm   = mv[ix] && (mt[ix] == tg);
    vdirty = !hitm && mv[ix] && md[ix];
    old = mdat[ix]; oldtag = mt[ix];
    exp_s = (!req || hitm) ? 0 : 2 + lat * (vdirty ? 2 : 1);
    txq.delete();
    rd = r; wr = w; addr = a; wdata = d;
    if (req && !hitm) begin
      mdat[ix] = mem_get({tg, ix}); mt[ix] = tg; mv[ix] = 1'b1; md[ix] = 1'b0;
    end
    stalls = 0;
    for (int n = 0; n <= exp_s; n++) begin
      #1;
      exp_data = (isr && n == exp_s) ? mdat[ix][wd*32 +: 32] : 32'h0;
      chk("stall", 32'(p1_stall_o), 32'(n < exp_s));
      chk("load_data", p1_data_o, exp_data);
      if (exp_s == 0) chk("no_mem_req", 32'(mem_enable_o), 32'h0);
      if (p1_stall_o) stalls++;
      @(posedge clk); #1;
    end
    if (w) begin
      mdat[ix][wd*32 +: 32] = d; md[ix] = 1'b1;
    end
    last_tx.delete();
    while (txq.size() > 0) last_tx.push_back(txq.pop_front());
    chk("txn_count", 32'(last_tx.size()), (!req || hitm) ? 32'd0 : (vdirty ? 32'd2 : 32'd1));
    if (req && !hitm) begin
      int k;
      k = 0;
      if (vdirty) begin
        chk("wb_addr", get_tx(0).addr, {oldtag, ix, 5'b0});
        chk("wb_write", 32'(get_tx(0).wr), 32'h1);
        chk_line("wb_data", get_tx(0).data, old);
        k = 1;
      end
      chk("fill_addr", get_tx(k).addr, {tg, ix, 5'b0});
      chk("fill_write", 32'(get_tx(k).wr), 32'h0);
    end
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s;
    logic [255:0] l;
    logic [255:0] old;
    logic [31:0] a;
    rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'h48; wdata = '0; ack_spur = 1'b0;
    model_clear();
    l = '0; l[95:64] = 32'h1234;
    mem[27'h2] = l;
    #2;
    chk("rst_enable", 32'(mem_enable_o), 32'h0);
    chk("rst_write", 32'(mem_write_o), 32'h0);
    chk("rst_addr", mem_addr_o, 32'h0);
    chk_line("rst_mdata", mem_data_o, '0);
    chk("rst_stall_idle", 32'(p1_stall_o), 32'h0);
    rd = 1'b1; #1;
    chk("rst_stall_load", 32'(p1_stall_o), 32'h1);
    chk("rst_data", p1_data_o, 32'h0);
    rd = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Cold read, then read hit
    lat = 10;
    access(1'b1, 1'b0, 32'h48, 32'h0, s);
    chk("cold_stalls", 32'(s), 32'd12);
    chk("cold_fill_addr", get_tx(0).addr, 32'h40);
    chk("cold_data", p1_data_o, 32'h1234);
    access(1'b1, 1'b0, 32'h48, 32'h0, s);
    chk("hit_stalls", 32'(s), 32'd0);
    chk("hit_data", p1_data_o, 32'h1234);

    // Write hit then evict
    access(1'b0, 1'b1, 32'h44, 32'hDEAD_BEEF, s);
    chk("wr_hit_stalls", 32'(s), 32'd0);
    access(1'b1, 1'b0, 32'h444, 32'h0, s);
    chk("evict_stalls", 32'(s), 32'd22);
    chk("evict_wb_addr", get_tx(0).addr, 32'h40);
    chk("evict_wb_write", 32'(get_tx(0).wr), 32'h1);
    l = get_tx(0).data;
    chk("evict_wb_word1", l[63:32], 32'hDEAD_BEEF);
    chk("evict_wb_word2", l[95:64], 32'h1234);
    chk("evict_fill_addr", get_tx(1).addr, 32'h440);

    // Write miss allocates, later eviction carries the store
    lat = 3;
    access(1'b0, 1'b1, 32'h800, 32'h55, s);
    chk("wmiss_stalls", 32'(s), 32'd5);
    chk("wmiss_fill_addr", get_tx(0).addr, 32'h800);
    access(1'b1, 1'b0, 32'hC00, 32'h0, s);
    l = get_tx(0).data;
    chk("wmiss_wb_addr", get_tx(0).addr, 32'h800);
    chk("wmiss_wb_word0", l[31:0], 32'h55);

    // Spurious ack while idle
    access(1'b0, 1'b1, 32'hC04, 32'h7777_0001, s);
    rd = 1'b0; wr = 1'b0;
    mem_rdata = '1; ack_spur = 1'b1;
    @(posedge clk); #1 ack_spur = 1'b0;
    @(posedge clk); #1;
    chk("spur_enable", 32'(mem_enable_o), 32'h0);
    chk("spur_txns", 32'(txq.size()), 32'h0);
    access(1'b1, 1'b0, 32'hC04, 32'h0, s);
    chk("spur_hit_data", p1_data_o, 32'h7777_0001);

    // CPU flush mid-miss: dirty victim still written back and fill completes
    lat = 4;
    old = mdat[0];
    txq.delete();
    rd = 1'b1; addr = 32'h3000;
    repeat (3) @(posedge clk);
    #1 rd = 1'b0;
    for (int k = 0; k < 60 && mem_enable_o; k++) begin
      @(posedge clk); #1;
    end
    chk("flush_done", 32'(mem_enable_o), 32'h0);
    @(posedge clk); #1;
    mdat[0] = mem_get(27'h180); mt[0] = 22'hC; mv[0] = 1'b1; md[0] = 1'b0;
    chk("flush_txns", 32'(txq.size()), 32'd2);
    last_tx.delete();
    while (txq.size() > 0) last_tx.push_back(txq.pop_front());
    chk("flush_wb_addr", get_tx(0).addr, 32'hC00);
    chk_line("flush_wb_data", get_tx(0).data, old);
    chk("flush_fill_addr", get_tx(1).addr, 32'h3000);
    access(1'b1, 1'b0, 32'h3004, 32'h0, s);
    access(1'b1, 1'b0, 32'hC04, 32'h0, s);
    chk("flush_reload_data", p1_data_o, 32'h7777_0001);

    // Reset in the middle of a refill
    lat = 8;
    rd = 1'b1; wr = 1'b0; addr = 32'h2060;
    for (int k = 0; k < 20 && !mem_enable_o; k++) begin
      @(posedge clk); #1;
    end
    chk("mid_enable_seen", 32'(mem_enable_o), 32'h1);
    @(posedge clk); #2;
    rst_n = 1'b0; #1;
    chk("mid_rst_enable", 32'(mem_enable_o), 32'h0);
    chk("mid_rst_addr", mem_addr_o, 32'h0);
    chk("mid_rst_stall", 32'(p1_stall_o), 32'h1);
    rd = 1'b0;
    model_clear();
    @(posedge clk); #1 rst_n = 1'b1;
    lat = 10;
    access(1'b1, 1'b0, 32'h48, 32'h0, s);
    chk("rst_reread_stalls", 32'(s), 32'd12);

    // Random traffic over a few conflicting indices
    for (int i = 0; i < 400; i++) begin
      logic r, w;
      int kind;
      lat = $urandom_range(1, 4);
      kind = $urandom_range(0, 15);
      r = (kind < 8) || (kind == 15);
      w = (kind >= 8) && (kind != 14);
      if (kind == 14) r = 1'b0;
      a = {22'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 2'b00};
      access(r, w, a, $urandom, s);
    end

    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
